// File: rtl/sim_dmi_responder.sv
// sim_dmi_responder: target end of a DMI link. Accepts one request at a time,
// answers it after a configurable delay, and models a minimal Debug Module
// register set plus a sticky test-finisher exit register.
module sim_dmi_responder #(
    parameter int DATA_COUNT = 4,
    parameter int LATENCY    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        debug_req_valid,
    output logic        debug_req_ready,
    input  logic [6:0]  debug_req_bits_addr,
    input  logic [1:0]  debug_req_bits_op,
    input  logic [31:0] debug_req_bits_data,
    output logic        debug_resp_valid,
    input  logic        debug_resp_ready,
    output logic [1:0]  debug_resp_bits_resp,
    output logic [31:0] debug_resp_bits_data,
    output logic [31:0] exit
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;

    localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS  = 7'h11;
    localparam logic [6:0] ADDR_HARTINFO  = 7'h12;
    localparam logic [6:0] ADDR_FINISHER  = 7'h7F;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q [DATA_COUNT];
    logic [31:0] data_d [DATA_COUNT];
    logic        haltreq_q, haltreq_d;
    logic        ndmreset_q, ndmreset_d;
    logic        dmactive_q, dmactive_d;
    logic [31:0] exit_q, exit_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;

    logic        known;
    logic        is_write;
    logic [31:0] rd_val;

    assign debug_req_ready      = (state_q == ST_IDLE) && !reset;
    assign debug_resp_valid     = (state_q == ST_RESP) && !reset;
    assign debug_resp_bits_resp = resp_q;
    assign debug_resp_bits_data = rdata_q;
    assign exit                 = exit_q;

    // Transaction sequencing plus request decode: register reads are taken from
    // current state, writes and the response buffer update on the accept edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        haltreq_d  = haltreq_q;
        ndmreset_d = ndmreset_q;
        dmactive_d = dmactive_q;
        exit_d     = exit_q;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        known      = 1'b0;
        rd_val     = '0;
        is_write   = (debug_req_bits_op == OP_WRITE);

        case (state_q)
            ST_IDLE: begin
                if (debug_req_valid) begin
                    for (int i = 0; i < DATA_COUNT; i++) begin
                        if (debug_req_bits_addr == 7'(4 + i)) begin
                            known  = 1'b1;
                            rd_val = dmactive_q ? data_q[i] : '0;
                            if (is_write && dmactive_q) begin
                                data_d[i] = debug_req_bits_data;
                            end
                        end
                    end

                    if (debug_req_bits_addr == ADDR_DMCONTROL) begin
                        known  = 1'b1;
                        rd_val = {haltreq_q, 29'b0, ndmreset_q, dmactive_q};
                        if (is_write) begin
                            haltreq_d  = debug_req_bits_data[31];
                            ndmreset_d = debug_req_bits_data[1];
                            dmactive_d = debug_req_bits_data[0];
                            if (!debug_req_bits_data[0]) begin
                                haltreq_d  = 1'b0;
                                ndmreset_d = 1'b0;
                                for (int i = 0; i < DATA_COUNT; i++) begin
                                    data_d[i] = '0;
                                end
                            end
                        end
                    end else if (debug_req_bits_addr == ADDR_DMSTATUS) begin
                        known  = 1'b1;
                        rd_val = 32'h2 | {22'b0, haltreq_q, haltreq_q, 8'b0};
                    end else if (debug_req_bits_addr == ADDR_HARTINFO) begin
                        known  = 1'b1;
                    end else if (debug_req_bits_addr == ADDR_FINISHER) begin
                        known  = 1'b1;
                        rd_val = exit_q;
                        if (is_write && (debug_req_bits_data != '0) && (exit_q == '0)) begin
                            exit_d = debug_req_bits_data;
                        end
                    end

                    if (debug_req_bits_op == OP_NOP) begin
                        resp_d  = RESP_OK;
                        rdata_d = '0;
                    end else if (!known || (debug_req_bits_op == 2'd3)) begin
                        resp_d  = RESP_FAIL;
                        rdata_d = '0;
                    end else begin
                        resp_d  = RESP_OK;
                        rdata_d = (debug_req_bits_op == OP_READ) ? rd_val : '0;
                    end

                    cnt_d   = LAT;
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (debug_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register file; synchronous reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            for (int i = 0; i < DATA_COUNT; i++) begin
                data_q[i] <= '0;
            end
            haltreq_q  <= 1'b0;
            ndmreset_q <= 1'b0;
            dmactive_q <= 1'b0;
            exit_q     <= '0;
            resp_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            haltreq_q  <= haltreq_d;
            ndmreset_q <= ndmreset_d;
            dmactive_q <= dmactive_d;
            exit_q     <= exit_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sim_dmi_responder.sv
// Testbench for sim_dmi_responder: directed scenarios followed by random
// transactions, all checked against a register-level reference model.
module tb_sim_dmi_responder;

    localparam int DATA_COUNT = 4;
    localparam int LATENCY    = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        debug_req_valid;
    logic        debug_req_ready;
    logic [6:0]  debug_req_bits_addr;
    logic [1:0]  debug_req_bits_op;
    logic [31:0] debug_req_bits_data;
    logic        debug_resp_valid;
    logic        debug_resp_ready;
    logic [1:0]  debug_resp_bits_resp;
    logic [31:0] debug_resp_bits_data;
    logic [31:0] exit;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_data [DATA_COUNT];
    logic        m_halt;
    logic        m_ndm;
    logic        m_act;
    logic [31:0] m_exit;

    logic [1:0]  last_resp;
    logic [31:0] last_data;

    sim_dmi_responder #(
        .DATA_COUNT(DATA_COUNT),
        .LATENCY   (LATENCY)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .debug_req_valid     (debug_req_valid),
        .debug_req_ready     (debug_req_ready),
        .debug_req_bits_addr (debug_req_bits_addr),
        .debug_req_bits_op   (debug_req_bits_op),
        .debug_req_bits_data (debug_req_bits_data),
        .debug_resp_valid    (debug_resp_valid),
        .debug_resp_ready    (debug_resp_ready),
        .debug_resp_bits_resp(debug_resp_bits_resp),
        .debug_resp_bits_data(debug_resp_bits_data),
        .exit                (exit)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DATA_COUNT; i++) m_data[i] = '0;
        m_halt = 1'b0;
        m_ndm  = 1'b0;
        m_act  = 1'b0;
        m_exit = '0;
    endtask

    // Register-level behaviour of one accepted request
    task automatic modelAccess(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd,
                               output logic [1:0] r, output logic [31:0] d);
        int          idx;
        bit          known;
        logic [31:0] val;
        idx   = int'(a) - 4;
        known = 1'b1;
        val   = '0;
        if (idx >= 0 && idx < DATA_COUNT) val = m_act ? m_data[idx] : 32'h0;
        else if (a == 7'h10) val = (m_halt ? 32'h8000_0000 : 32'h0) + (m_ndm ? 32'd2 : 32'd0) + (m_act ? 32'd1 : 32'd0);
        else if (a == 7'h11) val = 32'd2 + (m_halt ? 32'h300 : 32'h0);
        else if (a == 7'h12) val = '0;
        else if (a == 7'h7F) val = m_exit;
        else known = 1'b0;

        if (op == 2'd0) begin
            r = 2'd0; d = '0;
        end else if (op == 2'd3 || !known) begin
            r = 2'd2; d = '0;
        end else if (op == 2'd1) begin
            r = 2'd0; d = val;
        end else begin
            r = 2'd0; d = '0;
            if (idx >= 0 && idx < DATA_COUNT) begin
                if (m_act) m_data[idx] = wd;
            end else if (a == 7'h10) begin
                m_halt = wd[31];
                m_ndm  = wd[1];
                m_act  = wd[0];
                if (!wd[0]) begin
                    m_halt = 1'b0;
                    m_ndm  = 1'b0;
                    for (int i = 0; i < DATA_COUNT; i++) m_data[i] = '0;
                end
            end else if (a == 7'h7F) begin
                if (wd != '0 && m_exit == '0) m_exit = wd;
            end
        end
    endtask

    // One full transaction: request, timed wait, optional back-pressure, handshake
    task automatic applyStimulus(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd, input int hold);
        logic [1:0]  exp_r;
        logic [31:0] exp_d;
        logic [33:0] snap;
        int          waited;
        int          lat;
        bit          ready_bad;
        bit          stable_bad;

        @(negedge clk);
        debug_req_valid     = 1'b1;
        debug_req_bits_addr = a;
        debug_req_bits_op   = op;
        debug_req_bits_data = wd;
        waited = 0;
        while (!debug_req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!debug_req_ready) begin
            checkOutput("req_ready_timeout", {31'b0, debug_req_ready}, 32'd1);
            debug_req_valid = 1'b0;
            return;
        end
        modelAccess(a, op, wd, exp_r, exp_d);

        @(negedge clk);
        debug_req_valid     = 1'b0;
        debug_req_bits_addr = 7'($urandom);
        debug_req_bits_op   = 2'($urandom);
        debug_req_bits_data = $urandom;
        lat       = 1;
        ready_bad = 1'b0;
        while (!debug_resp_valid && lat < 40) begin
            if (debug_req_ready) ready_bad = 1'b1;
            debug_resp_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        debug_resp_ready = 1'b0;
        checkOutput("latency", 32'(lat), 32'(1 + LATENCY));
        checkOutput("resp", {30'b0, debug_resp_bits_resp}, {30'b0, exp_r});
        checkOutput("rdata", debug_resp_bits_data, exp_d);
        last_resp = debug_resp_bits_resp;
        last_data = debug_resp_bits_data;

        snap       = {debug_resp_bits_resp, debug_resp_bits_data};
        stable_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            debug_req_valid     = 1'b1;
            debug_req_bits_addr = 7'($urandom);
            debug_req_bits_op   = 2'd2;
            debug_req_bits_data = $urandom;
            @(negedge clk);
            if (debug_req_ready) ready_bad = 1'b1;
            if (!debug_resp_valid || {debug_resp_bits_resp, debug_resp_bits_data} != snap) stable_bad = 1'b1;
        end
        if (debug_req_ready) ready_bad = 1'b1;
        debug_req_valid  = 1'b0;
        debug_resp_ready = 1'b1;
        @(negedge clk);
        debug_resp_ready = 1'b0;
        checkOutput("ready_low_busy", {31'b0, ready_bad}, 32'd0);
        if (hold > 0) checkOutput("resp_stable", {31'b0, stable_bad}, 32'd0);
        checkOutput("post_hs_valid", {31'b0, debug_resp_valid}, 32'd0);
        checkOutput("post_hs_ready", {31'b0, debug_req_ready}, 32'd1);
        checkOutput("exit", exit, m_exit);
    endtask

    // Main sequence
    initial begin
        logic [6:0]  a;
        logic [1:0]  op;
        logic [31:0] wd;

        reset               = 1'b1;
        debug_req_valid     = 1'b0;
        debug_req_bits_addr = '0;
        debug_req_bits_op   = '0;
        debug_req_bits_data = '0;
        debug_resp_ready    = 1'b0;
        last_resp           = '0;
        last_data           = '0;
        modelReset();

        // Reset held, then released with no traffic
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, debug_req_ready}, 32'd0);
        checkOutput("rst_resp_valid", {31'b0, debug_resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t1_req_ready", {31'b0, debug_req_ready}, 32'd1);
        checkOutput("t1_resp_valid", {31'b0, debug_resp_valid}, 32'd0);
        checkOutput("t1_exit", exit, 32'd0);
        checkOutput("t1_resp_bits", {30'b0, debug_resp_bits_resp} | debug_resp_bits_data, 32'd0);

        // Basic write/readback with dmactive set
        applyStimulus(7'h10, 2'd2, 32'h1, 0);
        applyStimulus(7'h04, 2'd2, 32'hDEADBEEF, 0);
        applyStimulus(7'h04, 2'd1, 32'h0, 0);
        checkOutput("t2_data", last_data, 32'hDEADBEEF);

        // dmactive gating and dmstatus halt reflection
        applyStimulus(7'h10, 2'd2, 32'h0, 0);
        applyStimulus(7'h04, 2'd2, 32'h5, 0);
        applyStimulus(7'h04, 2'd1, 32'h0, 0);
        checkOutput("t3_gated", last_data, 32'h0);
        applyStimulus(7'h10, 2'd2, 32'h80000001, 0);
        applyStimulus(7'h11, 2'd1, 32'h0, 0);
        checkOutput("t3_dmstatus", last_data, 32'h302);

        // Error and nop responses
        applyStimulus(7'h20, 2'd1, 32'h0, 0);
        checkOutput("t4_bad_addr", {30'b0, last_resp}, 32'd2);
        applyStimulus(7'h04, 2'd3, 32'h0, 0);
        checkOutput("t4_op3", {30'b0, last_resp}, 32'd2);
        applyStimulus(7'h20, 2'd0, 32'h0, 0);
        checkOutput("t4_nop", {30'b0, last_resp}, 32'd0);

        // Back-pressure held for ten cycles
        applyStimulus(7'h10, 2'd1, 32'h0, 10);

        // Sticky finisher
        applyStimulus(7'h7F, 2'd2, 32'h1, 0);
        applyStimulus(7'h7F, 2'd2, 32'h7, 0);
        checkOutput("t6_exit_sticky", exit, 32'h1);

        // Reset while a transaction is waiting
        @(negedge clk);
        debug_req_valid     = 1'b1;
        debug_req_bits_addr = 7'h05;
        debug_req_bits_op   = 2'd2;
        debug_req_bits_data = 32'h1234;
        @(negedge clk);
        debug_req_valid = 1'b0;
        reset           = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_ready", {31'b0, debug_req_ready}, 32'd0);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("t6_idle_ready", {31'b0, debug_req_ready}, 32'd1);
        checkOutput("t6_exit_clr", exit, 32'd0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < LATENCY + 4; c++) begin
                if (debug_resp_valid) seen = 1'b1;
                @(negedge clk);
            end
            checkOutput("t6_no_resp", {31'b0, seen}, 32'd0);
        end

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = 7'(4 + $urandom_range(0, DATA_COUNT - 1));
                2:       a = 7'h10;
                3:       a = 7'h11;
                4:       a = 7'h12;
                5:       a = 7'h7F;
                6:       a = 7'(4 + DATA_COUNT);
                default: a = 7'($urandom);
            endcase
            op = 2'($urandom);
            wd = $urandom;
            if (a == 7'h10 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            applyStimulus(a, op, wd, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
